// File: rtl/stack.sv
// LIFO stack of WIDTH-bit words with registered pop output and occupancy/error flags.
// Push+pop in one cycle replaces the top entry (or passes data_in straight through when empty).
module stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int CNTW = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic             read,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic [CNTW-1:0]  count,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [CNTW-1:0]             sp;
  logic [AW-1:0]               top_idx, mem_idx;
  logic                        mem_we;

  assign empty   = (sp == '0);
  assign full    = (sp == CNTW'(DEPTH));
  assign count   = sp;
  assign top_idx = AW'(sp - CNTW'(1));

  // A push writes the free slot; a replace overwrites the current top.
  always_comb begin
    mem_we  = 1'b0;
    mem_idx = sp[AW-1:0];
    if (write && !read && !full) begin
      mem_we = 1'b1;
    end else if (write && read && !empty) begin
      mem_we  = 1'b1;
      mem_idx = top_idx;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset && mem_we)
      mem[mem_idx] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp        <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      unique case ({write, read})
        2'b10: begin
          if (!full) sp <= sp + CNTW'(1);
          else       overflow <= 1'b1;
        end
        2'b01: begin
          if (!empty) begin
            data_out <= mem[top_idx];
            sp       <= sp - CNTW'(1);
          end else begin
            underflow <= 1'b1;
          end
        end
        2'b11: begin
          if (!empty) data_out <= mem[top_idx];
          else        data_out <= data_in;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_stack.sv
// Directed bench for stack: push/pop ordering, hold, flags, replace-top, pass-through, reset.
module tb_stack;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int CNTW  = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             reset, write, read;
  logic [WIDTH-1:0] data_in, data_out;
  logic             empty, full, overflow, underflow;
  logic [CNTW-1:0]  count;

  int passed = 0;
  int total  = 0;

  stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .write(write), .read(read),
    .data_in(data_in), .data_out(data_out), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; read = 1'b0; data_in = '0;
    tick();
    reset = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_dout", data_out, 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_unf", 32'(underflow), 0);

    // Three pushes then pop back in reverse order.
    write = 1'b1;
    data_in = 32'h12345678; tick();
    data_in = 32'hAABBCCDD; tick();
    data_in = 32'h11223344; tick();
    write = 1'b0;
    check("push3_count", 32'(count), 3);
    read = 1'b1; tick(); read = 1'b0;
    check("pop1_dout", data_out, 32'h11223344);
    check("pop1_count", 32'(count), 2);
    repeat (20) tick();
    check("hold_dout", data_out, 32'h11223344);
    check("hold_count", 32'(count), 2);
    read = 1'b1; tick(); read = 1'b0;
    check("pop2_dout", data_out, 32'hAABBCCDD);
    read = 1'b1; tick(); read = 1'b0;
    check("pop3_dout", data_out, 32'h12345678);
    check("pop3_empty", 32'(empty), 1);

    // Underflow on empty stack.
    read = 1'b1; tick(); read = 1'b0;
    check("unf_dout", data_out, 32'h12345678);
    check("unf_pulse", 32'(underflow), 1);
    check("unf_count", 32'(count), 0);
    tick();
    check("unf_clear", 32'(underflow), 0);

    // Fill, then overflow.
    write = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      data_in = 32'(i); tick();
    end
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 16);
    check("fill_noovf", 32'(overflow), 0);
    data_in = 32'hDEADBEEF; tick(); write = 1'b0;
    check("ovf_pulse", 32'(overflow), 1);
    check("ovf_count", 32'(count), 16);
    tick();
    check("ovf_clear", 32'(overflow), 0);
    read = 1'b1;
    for (int i = DEPTH-1; i >= 0; i--) begin
      tick();
      check($sformatf("drain_%0d", i), data_out, 32'(i));
    end
    read = 1'b0;
    check("drain_empty", 32'(empty), 1);

    // Replace-top with two entries.
    write = 1'b1;
    data_in = 32'hA; tick();
    data_in = 32'hB; tick();
    read = 1'b1; data_in = 32'hC; tick();
    write = 1'b0;
    check("repl_dout", data_out, 32'hB);
    check("repl_count", 32'(count), 2);
    tick();
    check("repl_pop1", data_out, 32'hC);
    tick(); read = 1'b0;
    check("repl_pop2", data_out, 32'hA);
    check("repl_empty", 32'(empty), 1);

    // Pass-through on empty stack.
    write = 1'b1; read = 1'b1; data_in = 32'h55; tick();
    write = 1'b0; read = 1'b0;
    check("pt_dout", data_out, 32'h55);
    check("pt_count", 32'(count), 0);
    check("pt_ovf", 32'(overflow), 0);
    check("pt_unf", 32'(underflow), 0);

    // Reset mid-run with a concurrent pop.
    write = 1'b1;
    data_in = 32'h1; tick();
    data_in = 32'h2; tick();
    data_in = 32'h3; tick();
    write = 1'b0;
    check("mid_count3", 32'(count), 3);
    reset = 1'b1; read = 1'b1; tick();
    reset = 1'b0;
    check("mid_count", 32'(count), 0);
    check("mid_empty", 32'(empty), 1);
    check("mid_dout", data_out, 0);
    tick(); read = 1'b0;
    check("mid_unf", 32'(underflow), 1);
    check("mid_dout2", data_out, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
